// File: rtl/rover_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rover_pkg
//  Description : Shared widths, state codes and servo defaults for the rover
//                drive sequencer and its duty ramp.
//  Revision    : 1.0 - initial release
// ============================================================================
package rover_pkg;

    localparam int DUTY_W  = 12;    // motor PWM width resolution
    localparam int SERVO_W = 21;    // servo PWM width resolution

    // Servo timing defaults, in clk cycles
    localparam int c_SERVO_LO_DEFAULT   = 100000;
    localparam int c_SERVO_HI_DEFAULT   = 200000;
    localparam int c_SERVO_HOLD_DEFAULT = 100000000;

    // Sequencer state codes (also presented on the debug state output)
    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_DRIVE      = 3'd1;
    localparam logic [2:0] c_ST_BRAKE      = 3'd2;
    localparam logic [2:0] c_ST_WAIT_CLEAR = 3'd3;
    localparam logic [2:0] c_ST_SERVO_OUT  = 3'd4;
    localparam logic [2:0] c_ST_SERVO_BACK = 3'd5;

endpackage
`default_nettype wire

// File: rtl/duty_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : duty_ramp
//  Description : Moves a motor duty width toward a target by RAMP_STEP once
//                every RAMP_TICK cycles, landing exactly on the target.
//  Ports       : clk, reset   - clock, synchronous active-high reset
//                restart      - hold the tick counter at zero (no step taken)
//                target       - duty the width is ramping toward
//                width        - registered current duty
//  Revision    : 1.0 - initial release
// ============================================================================
module duty_ramp
    import rover_pkg::*;
#(
    parameter int unsigned RAMP_STEP = 16,
    parameter int unsigned RAMP_TICK = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic [DUTY_W-1:0] target,
    output logic [DUTY_W-1:0] width
);

    localparam int c_TICK_W = (RAMP_TICK > 1) ? $clog2(RAMP_TICK) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(RAMP_TICK - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
    localparam logic [DUTY_W:0]     c_STEP_X    = (DUTY_W + 1)'(RAMP_STEP);
    localparam logic [DUTY_W-1:0]   c_STEP      = DUTY_W'(RAMP_STEP);

    logic [c_TICK_W-1:0] r_tick;
    logic [DUTY_W-1:0]   r_width;

    // One extra bit so the step comparisons can never wrap
    logic [DUTY_W:0]     w_cur_x;
    logic [DUTY_W:0]     w_tgt_x;
    logic [DUTY_W:0]     w_up;
    logic [DUTY_W:0]     w_down_lim;
    logic [DUTY_W-1:0]   w_next;

    assign w_cur_x    = {1'b0, r_width};
    assign w_tgt_x    = {1'b0, target};
    assign w_up       = w_cur_x + c_STEP_X;
    assign w_down_lim = w_tgt_x + c_STEP_X;

    always_comb begin
        w_next = r_width;
        if (r_width < target) begin
            w_next = (w_up >= w_tgt_x) ? target : w_up[DUTY_W-1:0];
        end else if (r_width > target) begin
            // Subtraction is safe: width exceeds target+step here
            w_next = (w_cur_x <= w_down_lim) ? target : (r_width - c_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick  <= '0;
            r_width <= '0;
        end else if (restart) begin
            r_tick  <= '0;
        end else if (r_tick == c_TICK_LAST) begin
            r_tick  <= '0;
            r_width <= w_next;
        end else begin
            r_tick  <= r_tick + c_TICK_ONE;
        end
    end

    assign width = r_width;

endmodule
`default_nettype wire

// File: rtl/drive_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : drive_sequencer
//  Description : Mission-level rover controller: soft-start drive, braking
//                ramp, obstacle wait-until-clear and timed servo deploy at
//                each station marker.
//  Ports       : clk, reset     - clock, synchronous active-high reset
//                sw_ON          - run enable
//                dist_flag      - obstacle present
//                marker         - station marker present
//                line_in        - requested H-bridge direction
//                target_duty    - cruise motor duty
//                motor_width    - motor PWM width
//                EN, IN         - H-bridge enables / direction
//                servo_width    - servo PWM width
//                state          - current state code
//                station_cnt    - stations serviced (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module drive_sequencer
    import rover_pkg::*;
#(
    parameter int unsigned RAMP_STEP  = 16,
    parameter int unsigned RAMP_TICK  = 100000,
    parameter int unsigned OBST_DEB   = 1000,
    parameter int unsigned CLEAR_CYC  = 50000000,
    parameter int unsigned SERVO_LO   = c_SERVO_LO_DEFAULT,
    parameter int unsigned SERVO_HI   = c_SERVO_HI_DEFAULT,
    parameter int unsigned SERVO_HOLD = c_SERVO_HOLD_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sw_ON,
    input  logic               dist_flag,
    input  logic               marker,
    input  logic [3:0]         line_in,
    input  logic [DUTY_W-1:0]  target_duty,
    output logic [DUTY_W-1:0]  motor_width,
    output logic [1:0]         EN,
    output logic [3:0]         IN,
    output logic [SERVO_W-1:0] servo_width,
    output logic [2:0]         state,
    output logic [3:0]         station_cnt
);

    localparam int c_DEB_W  = $clog2(OBST_DEB + 1);
    localparam int c_CLR_W  = (CLEAR_CYC > 1) ? $clog2(CLEAR_CYC) : 1;
    localparam int c_HOLD_W = (SERVO_HOLD > 1) ? $clog2(SERVO_HOLD) : 1;

    localparam logic [c_DEB_W-1:0]  c_DEB_MAX  = c_DEB_W'(OBST_DEB);
    localparam logic [c_DEB_W-1:0]  c_DEB_ONE  = c_DEB_W'(1);
    localparam logic [c_CLR_W-1:0]  c_CLR_LAST = c_CLR_W'(CLEAR_CYC - 1);
    localparam logic [c_CLR_W-1:0]  c_CLR_ONE  = c_CLR_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(SERVO_HOLD - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
    localparam logic [SERVO_W-1:0]  c_SERVO_LO = SERVO_W'(SERVO_LO);
    localparam logic [SERVO_W-1:0]  c_SERVO_HI = SERVO_W'(SERVO_HI);

    logic [2:0]          r_state;
    logic [2:0]          r_ret;          // where BRAKE goes once stopped
    logic [1:0]          r_en;
    logic [3:0]          r_in;
    logic [SERVO_W-1:0]  r_servo;
    logic [3:0]          r_station_cnt;
    logic [c_DEB_W-1:0]  r_obst_cnt;
    logic [c_CLR_W-1:0]  r_clear_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_marker_d;
    logic                r_arm;

    logic [DUTY_W-1:0]   w_width;
    logic [DUTY_W-1:0]   w_ramp_target;
    logic                w_ramp_restart;
    logic                w_obst_deb;
    logic                w_marker_rise;
    logic                w_station_evt;
    logic                w_brake_req;
    logic [2:0]          w_brake_exit;

    assign w_obst_deb    = (r_obst_cnt == c_DEB_MAX);
    assign w_marker_rise = marker & ~r_marker_d;

    // A station stop only counts when nothing of higher priority claims the
    // cycle; otherwise the edge is dropped and the arm is left untouched.
    assign w_station_evt = (r_state == c_ST_DRIVE) & sw_ON & ~w_obst_deb &
                           w_marker_rise & r_arm;
    assign w_brake_req   = (r_state == c_ST_DRIVE) &
                           (~sw_ON | w_obst_deb | w_station_evt);
    assign w_brake_exit  = sw_ON ? r_ret : c_ST_IDLE;

    // The tick counter sits at zero outside the ramping states and is cleared
    // on the DRIVE->BRAKE edge, so every ramp phase starts a full tick late.
    assign w_ramp_restart = w_brake_req |
                            ~((r_state == c_ST_DRIVE) | (r_state == c_ST_BRAKE));
    assign w_ramp_target  = (r_state == c_ST_DRIVE) ? target_duty : '0;

    duty_ramp #(
        .RAMP_STEP (RAMP_STEP),
        .RAMP_TICK (RAMP_TICK)
    ) u_duty_ramp (
        .clk     (clk),
        .reset   (reset),
        .restart (w_ramp_restart),
        .target  (w_ramp_target),
        .width   (w_width)
    );

    // Obstacle debounce and station marker edge / arm tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_obst_cnt <= '0;
            r_marker_d <= 1'b0;
            r_arm      <= 1'b1;
        end else begin
            if (!dist_flag) begin
                r_obst_cnt <= '0;
            end else if (r_obst_cnt != c_DEB_MAX) begin
                r_obst_cnt <= r_obst_cnt + c_DEB_ONE;
            end
            r_marker_d <= marker;
            if (w_station_evt) begin
                r_arm <= 1'b0;
            end else if ((r_state == c_ST_DRIVE) && !marker) begin
                r_arm <= 1'b1;
            end
        end
    end

    // Main sequencer; outputs are updated together with the state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_ret         <= c_ST_IDLE;
            r_en          <= 2'b00;
            r_in          <= 4'b0000;
            r_servo       <= c_SERVO_LO;
            r_station_cnt <= 4'd0;
            r_clear_cnt   <= '0;
            r_hold_cnt    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (sw_ON) begin
                        r_state <= c_ST_DRIVE;
                        r_en    <= 2'b11;
                        r_in    <= line_in;
                    end
                end

                c_ST_DRIVE: begin
                    if (w_brake_req) begin
                        // IN keeps its last DRIVE value through the brake
                        r_state <= c_ST_BRAKE;
                        if (!sw_ON) begin
                            r_ret <= c_ST_IDLE;
                        end else if (w_obst_deb) begin
                            r_ret <= c_ST_WAIT_CLEAR;
                        end else begin
                            r_ret <= c_ST_SERVO_OUT;
                        end
                    end else begin
                        r_in <= line_in;
                    end
                end

                c_ST_BRAKE: begin
                    if (w_width == '0) begin
                        r_state <= w_brake_exit;
                        r_en    <= 2'b00;
                        r_in    <= 4'b0000;
                        if (w_brake_exit == c_ST_SERVO_OUT) begin
                            r_servo <= c_SERVO_HI;
                        end
                    end else if (!sw_ON) begin
                        r_ret <= c_ST_IDLE;
                    end
                end

                c_ST_WAIT_CLEAR: begin
                    if (!sw_ON) begin
                        r_state     <= c_ST_IDLE;
                        r_clear_cnt <= '0;
                    end else if (dist_flag) begin
                        r_clear_cnt <= '0;
                    end else if (r_clear_cnt == c_CLR_LAST) begin
                        r_state     <= c_ST_DRIVE;
                        r_clear_cnt <= '0;
                        r_en        <= 2'b11;
                        r_in        <= line_in;
                    end else begin
                        r_clear_cnt <= r_clear_cnt + c_CLR_ONE;
                    end
                end

                c_ST_SERVO_OUT: begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_state    <= c_ST_SERVO_BACK;
                        r_hold_cnt <= '0;
                        r_servo    <= c_SERVO_LO;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
                    end
                end

                c_ST_SERVO_BACK: begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_hold_cnt    <= '0;
                        r_station_cnt <= r_station_cnt + 4'd1;
                        if (sw_ON) begin
                            r_state <= c_ST_DRIVE;
                            r_en    <= 2'b11;
                            r_in    <= line_in;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_en    <= 2'b00;
                    r_in    <= 4'b0000;
                    r_servo <= c_SERVO_LO;
                end
            endcase
        end
    end

    assign motor_width = w_width;
    assign EN          = r_en;
    assign IN          = r_in;
    assign servo_width = r_servo;
    assign state       = r_state;
    assign station_cnt = r_station_cnt;

endmodule
`default_nettype wire

// File: tb/tb_drive_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_drive_sequencer
//  Description : Scoreboard bench for drive_sequencer. Each clock the
//                reference model advances on the sampled inputs and queues
//                the expected outputs; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_drive_sequencer;
    import rover_pkg::*;

    localparam int TB_STEP  = 16;
    localparam int TB_TICK  = 4;
    localparam int TB_DEB   = 3;
    localparam int TB_CLEAR = 10;
    localparam int TB_LO    = 100000;
    localparam int TB_HI    = 200000;
    localparam int TB_HOLD  = 8;

    localparam int M_IDLE  = int'(c_ST_IDLE);
    localparam int M_DRIVE = int'(c_ST_DRIVE);
    localparam int M_BRAKE = int'(c_ST_BRAKE);
    localparam int M_WAIT  = int'(c_ST_WAIT_CLEAR);
    localparam int M_OUT   = int'(c_ST_SERVO_OUT);
    localparam int M_BACK  = int'(c_ST_SERVO_BACK);

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sw_ON = 1'b0;
    logic               dist_flag = 1'b0;
    logic               marker = 1'b0;
    logic [3:0]         line_in = 4'd0;
    logic [DUTY_W-1:0]  target_duty = '0;
    logic [DUTY_W-1:0]  motor_width;
    logic [1:0]         EN;
    logic [3:0]         IN;
    logic [SERVO_W-1:0] servo_width;
    logic [2:0]         state;
    logic [3:0]         station_cnt;

    drive_sequencer #(
        .RAMP_STEP  (TB_STEP),
        .RAMP_TICK  (TB_TICK),
        .OBST_DEB   (TB_DEB),
        .CLEAR_CYC  (TB_CLEAR),
        .SERVO_LO   (TB_LO),
        .SERVO_HI   (TB_HI),
        .SERVO_HOLD (TB_HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_ON       (sw_ON),
        .dist_flag   (dist_flag),
        .marker      (marker),
        .line_in     (line_in),
        .target_duty (target_duty),
        .motor_width (motor_width),
        .EN          (EN),
        .IN          (IN),
        .servo_width (servo_width),
        .state       (state),
        .station_cnt (station_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] st;
        logic [31:0] mw;
        logic [31:0] en;
        logic [31:0] dir;
        logic [31:0] servo;
        logic [31:0] sc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // ---------------- reference model (phase-level behaviour) ----------------
    int m_st = M_IDLE;
    int m_w = 0;          // motor duty
    int m_age = 0;        // edges spent in the current ramping phase
    int m_ret = M_IDLE;
    int m_hi_run = 0;     // consecutive high dist_flag samples so far
    int m_prev_mk = 0;
    int m_arm = 1;
    int m_quiet = 0;      // consecutive clear samples inside WAIT_CLEAR
    int m_dwell = 0;
    int m_cnt = 0;
    int m_in = 0;

    function automatic int approach(input int w, input int t);
        if (w < t) return (t - w <= TB_STEP) ? t : w + TB_STEP;
        if (w > t) return (w - t <= TB_STEP) ? t : w - TB_STEP;
        return w;
    endfunction

    task automatic model_step();
        int deb;
        int edge_seen;
        int nst;
        if (reset) begin
            m_st = M_IDLE; m_w = 0; m_age = 0; m_ret = M_IDLE; m_hi_run = 0;
            m_prev_mk = 0; m_arm = 1; m_quiet = 0; m_dwell = 0; m_cnt = 0; m_in = 0;
            return;
        end
        deb       = (m_hi_run >= TB_DEB) ? 1 : 0;
        edge_seen = (marker && m_prev_mk == 0) ? 1 : 0;
        nst       = m_st;
        case (m_st)
            M_IDLE: if (sw_ON) nst = M_DRIVE;
            M_DRIVE: begin
                if (!sw_ON) begin
                    nst = M_BRAKE; m_ret = M_IDLE;
                end else if (deb != 0) begin
                    nst = M_BRAKE; m_ret = M_WAIT;
                end else if (edge_seen != 0 && m_arm != 0) begin
                    nst = M_BRAKE; m_ret = M_OUT; m_arm = 0;
                end
                if (!marker) m_arm = 1;
                if (nst == M_DRIVE) begin
                    m_age++;
                    if (m_age % TB_TICK == 0) m_w = approach(m_w, int'(target_duty));
                    m_in = int'(line_in);
                end else begin
                    m_age = 0;
                end
            end
            M_BRAKE: begin
                if (m_w == 0) begin
                    nst = sw_ON ? m_ret : M_IDLE;
                end else begin
                    if (!sw_ON) m_ret = M_IDLE;
                    m_age++;
                    if (m_age % TB_TICK == 0) m_w = approach(m_w, 0);
                end
            end
            M_WAIT: begin
                if (!sw_ON) nst = M_IDLE;
                else if (dist_flag) m_quiet = 0;
                else begin
                    m_quiet++;
                    if (m_quiet == TB_CLEAR) nst = M_DRIVE;
                end
            end
            M_OUT: begin
                m_dwell++;
                if (m_dwell == TB_HOLD) begin nst = M_BACK; m_dwell = 0; end
            end
            M_BACK: begin
                m_dwell++;
                if (m_dwell == TB_HOLD) begin
                    m_dwell = 0;
                    m_cnt = (m_cnt + 1) % 16;
                    nst = sw_ON ? M_DRIVE : M_IDLE;
                end
            end
            default: nst = M_IDLE;
        endcase
        if (nst != M_WAIT) m_quiet = 0;
        if (nst == M_DRIVE && m_st != M_DRIVE) begin
            m_in = int'(line_in);
            m_age = 0;
        end
        m_hi_run  = dist_flag ? m_hi_run + 1 : 0;
        m_prev_mk = marker ? 1 : 0;
        m_st      = nst;
    endtask

    task automatic push_exp();
        exp_t e;
        e.st    = m_st;
        e.mw    = m_w;
        e.en    = (m_st == M_DRIVE || m_st == M_BRAKE) ? 3 : 0;
        e.dir   = (e.en != 0) ? m_in : 0;
        e.servo = (m_st == M_OUT) ? TB_HI : TB_LO;
        e.sc    = m_cnt;
        q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state",       32'(state),       e.st);
                chk("motor_width", 32'(motor_width), e.mw);
                chk("EN",          32'(EN),          e.en);
                chk("IN",          32'(IN),          e.dir);
                chk("servo_width", 32'(servo_width), e.servo);
                chk("station_cnt", 32'(station_cnt), e.sc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            model_step();
            push_exp();
            line_in = 4'($urandom);
        end
    endtask

    task automatic wait_state(input int s, input int budget, input string what);
        int n;
        n = 0;
        while (m_st != s && n < budget) begin
            run(1);
            n++;
        end
        if (m_st != s) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_%s: state %0d not reached within %0d cycles", what, s, budget);
        end
    endtask

    initial begin
        // Reset, then soft start to 64
        run(3);
        reset = 1'b0;
        run(2);
        sw_ON = 1'b1;
        target_duty = 12'd64;
        run(25);

        // Short obstacle glitch, then a real obstacle and a restarted clear
        dist_flag = 1'b1; run(2);
        dist_flag = 1'b0; run(5);
        dist_flag = 1'b1; run(4);
        dist_flag = 1'b0;
        wait_state(M_WAIT, 30, "clear1");
        run(7);
        dist_flag = 1'b1; run(1);
        dist_flag = 1'b0;
        wait_state(M_DRIVE, 30, "resume1");
        run(20);

        // Station stop with marker held high throughout
        marker = 1'b1;
        wait_state(M_OUT, 30, "servo_out1");
        wait_state(M_BACK, 12, "servo_back1");
        wait_state(M_DRIVE, 12, "drive_after_station");
        run(30);
        marker = 1'b0;
        run(3);

        // sw_ON dropped during servo, then dropped in DRIVE
        marker = 1'b1;
        wait_state(M_OUT, 30, "servo_out2");
        run(3);
        sw_ON = 1'b0;
        wait_state(M_IDLE, 40, "idle_after_servo");
        marker = 1'b0;
        sw_ON = 1'b1;
        run(20);
        sw_ON = 1'b0;
        wait_state(M_IDLE, 40, "idle_after_drive");
        sw_ON = 1'b1;
        run(20);

        // Debounced obstacle and marker edge on the same cycle
        dist_flag = 1'b1; run(3);
        marker = 1'b1;    run(1);
        dist_flag = 1'b0;
        wait_state(M_WAIT, 30, "clear2");
        wait_state(M_DRIVE, 30, "resume2");
        marker = 1'b0;
        run(20);

        // Reset in the middle of a brake at width 32
        sw_ON = 1'b0;
        begin
            int n;
            n = 0;
            while (!(m_st == M_BRAKE && m_w == 32) && n < 30) begin
                run(1);
                n++;
            end
            if (!(m_st == M_BRAKE && m_w == 32)) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wait_brake32: width 32 in BRAKE not reached");
            end
        end
        reset = 1'b1; run(1);
        reset = 1'b0; run(2);
        sw_ON = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 19) == 0)  dist_flag = ~dist_flag;
            if ($urandom_range(0, 29) == 0)  marker = ~marker;
            if ($urandom_range(0, 99) == 0)  sw_ON = ~sw_ON;
            if ($urandom_range(0, 49) == 0)  target_duty = 12'($urandom_range(0, 200));
            reset = ($urandom_range(0, 399) == 0);
            run(1);
        end
        reset = 1'b0;
        run(2);

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
